// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: default sizing and FSM state encoding.
package uart_pkg;
   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_START_TIMEOUT = 15;
   localparam int DEF_CLKS_PER_BIT  = 868;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;
endpackage

// File: rtl/uart_tx_arb_if.sv
// Link between the arbiter (master) and a single uart_tx (slave).
interface uart_tx_arb_if;
   // uart_start is a one-cycle request, issued only while uart_busy=0; uart_data is stable
   // from then until the frame ends; uart_busy covers the frame and uart_done pulses once at its end.
   logic       uart_start;
   logic [7:0] uart_data;
   logic       uart_busy;
   logic       uart_done;

   modport master (output uart_start, output uart_data, input uart_busy, input uart_done);
   modport slave  (input uart_start, input uart_data, output uart_busy, output uart_done);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr+1 modulo NUM_REQ.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       valid
);
   localparam int IW = $clog2(NUM_REQ);

   int idx;

   // Scan from the farthest offset down so the nearest requester after ptr wins last.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx[IW-1:0]]) begin
            winner = idx[IW-1:0];
            valid  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit, CLKS_PER_BIT clocks each.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int CKW = $clog2(CLKS_PER_BIT);
   localparam logic [CKW-1:0] LAST_CLK = CKW'(CLKS_PER_BIT - 1);

   logic [9:0]     shreg;
   logic [3:0]     bit_cnt;
   logic [CKW-1:0] clk_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx      <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         shreg   <= '1;
         bit_cnt <= '0;
         clk_cnt <= '0;
      end else begin
         tx_done <= 1'b0;
         if (!tx_busy) begin
            if (start) begin
               shreg   <= {1'b1, data_in, 1'b0};
               tx      <= 1'b0;
               tx_busy <= 1'b1;
               bit_cnt <= '0;
               clk_cnt <= '0;
            end
         end else if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               tx_busy <= 1'b0;
               tx_done <= 1'b1;
               tx      <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shreg   <= {1'b1, shreg[9:1]};
               tx      <= shreg[1];
            end
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter letting NUM_REQ byte requesters share one uart_tx, with a start timeout.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       err,
   output logic [1:0]                 fsm_state,
   uart_tx_arb_if.master              bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(START_TIMEOUT);

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] pick;
   logic          pick_valid;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc   = cnt + 1'b1;
   assign fsm_state = state;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick),
      .valid  (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         ptr            <= IW'(NUM_REQ - 1);
         owner          <= '0;
         gnt            <= '0;
         done           <= '0;
         err            <= 1'b0;
         cnt            <= '0;
         bus.uart_start <= 1'b0;
         bus.uart_data  <= '0;
      end else begin
         gnt            <= '0;
         done           <= '0;
         bus.uart_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A still-busy uart_tx (e.g. after a reset mid-frame) blocks new grants.
               if (pick_valid && !bus.uart_busy) begin
                  owner         <= pick;
                  bus.uart_data <= req_data[{pick, 3'b000} +: 8];
                  gnt           <= NUM_REQ'(1) << pick;
                  state         <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               bus.uart_start <= 1'b1;
               cnt            <= '0;
               state          <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (bus.uart_busy) begin
                  state <= ST_WAIT_DONE;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == TIMEOUT_VAL) begin
                     err   <= 1'b1;
                     ptr   <= owner;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (bus.uart_done) begin
                  done  <= NUM_REQ'(1) << owner;
                  ptr   <= owner;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb driving a real uart_tx (CLKS_PER_BIT=4), with a stub mode for timeouts.
module tb_uart_tx_arb;
   import uart_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        tx_rst_n;
   logic        stub;
   logic        auto_drop;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [1:0]  owner;
   logic        err;
   logic [1:0]  fsm_state;
   logic        tx_line;
   logic        tx_busy;
   logic        tx_done;

   int checks   = 0;
   int failures = 0;

   logic [1:0] exp_gnt_q[$];
   logic [7:0] exp_byte_q[$];
   logic [1:0] exp_done_q[$];
   logic [7:0] exp_ser_q[$];

   uart_tx_arb_if bus ();

   assign bus.uart_busy = stub ? 1'b0 : tx_busy;
   assign bus.uart_done = stub ? 1'b0 : tx_done;

   uart_tx_arb #(.NUM_REQ(4), .START_TIMEOUT(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .done      (done),
      .owner     (owner),
      .err       (err),
      .fsm_state (fsm_state),
      .bus       (bus)
   );

   uart_tx #(.CLKS_PER_BIT(4)) u_uart (
      .clk     (clk),
      .rst_n   (tx_rst_n),
      .start   (bus.uart_start),
      .data_in (bus.uart_data),
      .tx      (tx_line),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant / done / start / data-hold monitor.
   logic [1:0] mon_g;
   logic [7:0] mon_b;
   logic [1:0] mon_d;
   logic       prev_gnt_any = 1'b0;
   logic       prev_rst     = 1'b0;
   logic [7:0] last_data    = 8'h00;
   initial forever begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
         checks++;
         if (!$onehot(gnt) || exp_gnt_q.size() == 0) begin
            failures++;
            $display("FAIL gnt_seq: got gnt=%b, expected grants pending=%0d", gnt, exp_gnt_q.size());
         end else begin
            mon_g = exp_gnt_q.pop_front();
            mon_b = exp_byte_q.pop_front();
            if (gnt !== (4'b0001 << mon_g) || owner !== mon_g || bus.uart_data !== mon_b) begin
               failures++;
               $display("FAIL gnt_seq: got gnt=%b owner=%0d data=%h, want gnt idx %0d data %h",
                        gnt, owner, bus.uart_data, mon_g, mon_b);
            end
         end
      end
      if (done !== 4'b0000) begin
         checks++;
         if (!$onehot(done) || exp_done_q.size() == 0) begin
            failures++;
            $display("FAIL done_seq: got done=%b, expected dones pending=%0d", done, exp_done_q.size());
         end else begin
            mon_d = exp_done_q.pop_front();
            if (done !== (4'b0001 << mon_d)) begin
               failures++;
               $display("FAIL done_seq: got done=%b want idx %0d", done, mon_d);
            end
         end
      end
      if (bus.uart_start !== 1'b0 || prev_gnt_any) begin
         checks++;
         if (bus.uart_start !== prev_gnt_any || (bus.uart_start && bus.uart_busy)) begin
            failures++;
            $display("FAIL start_timing: uart_start=%b prev_gnt=%b uart_busy=%b",
                     bus.uart_start, prev_gnt_any, bus.uart_busy);
         end
      end
      if (rst_n && prev_rst && gnt === 4'b0000) begin
         checks++;
         if (bus.uart_data !== last_data) begin
            failures++;
            $display("FAIL data_hold: uart_data=%h changed from %h without a grant", bus.uart_data, last_data);
         end
      end
      prev_gnt_any = (gnt !== 4'b0000);
      prev_rst     = rst_n;
      last_data    = bus.uart_data;
   end

   // Serial line decoder: samples mid-bit, compares against bytes expected on the wire.
   logic [7:0] ser_byte;
   logic [7:0] ser_exp;
   initial forever begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
         repeat (6) @(negedge clk);
         for (int b = 0; b < 8; b++) begin
            ser_byte[b] = tx_line;
            if (b < 7) repeat (4) @(negedge clk);
         end
         repeat (4) @(negedge clk);
         checks++;
         if (tx_line !== 1'b1 || exp_ser_q.size() == 0) begin
            failures++;
            $display("FAIL serial_frame: byte=%h stop=%b expected frames pending=%0d",
                     ser_byte, tx_line, exp_ser_q.size());
         end else begin
            ser_exp = exp_ser_q.pop_front();
            if (ser_byte !== ser_exp) begin
               failures++;
               $display("FAIL serial_frame: got %h want %h", ser_byte, ser_exp);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      if (auto_drop) req = req & ~gnt;
   endtask

   task automatic expect_txn(input logic [1:0] idx, input logic [7:0] b, input bit with_done,
                             input bit with_frame);
      exp_gnt_q.push_back(idx);
      exp_byte_q.push_back(b);
      if (with_done) exp_done_q.push_back(idx);
      if (with_frame) exp_ser_q.push_back(b);
   endtask

   task automatic wait_gnt(input int idx, input int budget, input string name);
      int n;
      n = 0;
      while (gnt[idx] !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_gnt: no gnt[%0d] within %0d cycles, gnt=%b", name, idx, budget, gnt);
      end
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, input string name);
      int n;
      n = 0;
      while (fsm_state !== st && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_state: state=%0d want %0d within %0d cycles", name, fsm_state, st, budget);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_gnt_q.size() != 0 || exp_done_q.size() != 0 || exp_ser_q.size() != 0 ||
              fsm_state !== ST_IDLE || bus.uart_busy !== 1'b0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_drain: pending gnt=%0d done=%0d frames=%0d state=%0d",
                  name, exp_gnt_q.size(), exp_done_q.size(), exp_ser_q.size(), fsm_state);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      checks++;
      if (gnt !== 4'b0 || done !== 4'b0 || bus.uart_start !== 1'b0 || bus.uart_data !== 8'h00 ||
          owner !== 2'd0 || err !== 1'b0 || fsm_state !== ST_IDLE) begin
         failures++;
         $display("FAIL %s_outputs: gnt=%b done=%b start=%b data=%h owner=%0d err=%b state=%0d, want all 0",
                  name, gnt, done, bus.uart_start, bus.uart_data, owner, err, fsm_state);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tx_rst_n = 1'b0; stub = 1'b0; auto_drop = 1'b1;
      req = 4'b0; req_data = 32'h0;
      repeat (3) step();
      check_zero_outputs("reset");
      checks++;
      if (tx_line !== 1'b1 || bus.uart_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_line: tx=%b busy=%b want 1 0", tx_line, bus.uart_busy);
      end
      rst_n = 1'b1; tx_rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int n;
      req_data = 32'h00A5_0000;
      expect_txn(2'd2, 8'hA5, 1'b1, 1'b1);
      req = 4'b0100;
      wait_gnt(2, 20, "single");
      checks++;
      if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt: got %b want 0100", gnt); end
      step();
      checks++;
      if (bus.uart_start !== 1'b1 || gnt !== 4'b0) begin
         failures++;
         $display("FAIL single_start: start=%b gnt=%b want 1 0000", bus.uart_start, gnt);
      end
      step();
      checks++;
      if (bus.uart_start !== 1'b0) begin failures++; $display("FAIL single_start_len: got %b want 0", bus.uart_start); end
      n = 0;
      while (done === 4'b0 && n < 100) begin step(); n++; end
      checks++;
      if (done !== 4'b0100) begin failures++; $display("FAIL single_done: got %b want 0100", done); end
      step();
      checks++;
      if (done !== 4'b0) begin failures++; $display("FAIL single_done_len: got %b want 0000", done); end
      wait_idle(100, "single");
   endtask

   task automatic test_round_robin();
      int  n, ngnt;
      bit  outstanding;
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      req_data = 32'h4433_2211;
      for (int i = 0; i < 4; i++) expect_txn(2'(i), 8'(8'h11 * (i + 1)), 1'b1, 1'b1);
      req = 4'b1111;
      n = 0; ngnt = 0; outstanding = 1'b0;
      while ((exp_gnt_q.size() != 0 || exp_done_q.size() != 0) && n < 600) begin
         step();
         n++;
         if (done !== 4'b0) outstanding = 1'b0;
         if (gnt !== 4'b0) begin
            checks++;
            if (outstanding) begin failures++; $display("FAIL rr_overlap: gnt=%b before previous done", gnt); end
            outstanding = 1'b1;
            ngnt++;
         end
      end
      checks++;
      if (ngnt != 4 || owner !== 2'd3) begin
         failures++;
         $display("FAIL rr_count: grants=%0d owner=%0d want 4 and 3", ngnt, owner);
      end
      wait_idle(100, "rr");
   endtask

   task automatic test_fairness();
      int n, ngnt;
      auto_drop = 1'b0;
      req_data = 32'hC300_005A;
      expect_txn(2'd0, 8'h5A, 1'b1, 1'b1);
      expect_txn(2'd3, 8'hC3, 1'b1, 1'b1);
      expect_txn(2'd0, 8'h5A, 1'b1, 1'b1);
      expect_txn(2'd3, 8'hC3, 1'b1, 1'b1);
      req = 4'b1001;
      n = 0; ngnt = 0;
      while (ngnt < 4 && n < 600) begin
         step();
         n++;
         if (gnt !== 4'b0) ngnt++;
      end
      req = 4'b0;
      auto_drop = 1'b1;
      checks++;
      if (ngnt != 4) begin failures++; $display("FAIL fair_count: grants=%0d want 4", ngnt); end
      wait_idle(200, "fair");
   endtask

   task automatic test_dropout();
      int n1;
      req_data = 32'h0000_EE3C;
      expect_txn(2'd0, 8'h3C, 1'b1, 1'b1);
      req = 4'b0001;
      wait_gnt(0, 20, "drop");
      wait_state(ST_WAIT_DONE, 20, "drop");
      n1 = 0;
      req = req | 4'b0010;
      repeat (2) begin step(); if (gnt[1] === 1'b1) n1++; end
      req = req & 4'b1101;
      repeat (80) begin step(); if (gnt[1] === 1'b1) n1++; end
      checks++;
      if (n1 != 0) begin failures++; $display("FAIL drop_gnt1: requester 1 granted %0d times want 0", n1); end
      wait_idle(100, "drop");
   endtask

   task automatic test_timeout();
      int  n;
      bit  saw_done;
      tx_rst_n = 1'b0;
      stub = 1'b1;
      req_data = 32'h0077_9900;
      expect_txn(2'd2, 8'h77, 1'b0, 1'b0);
      req = 4'b0100;
      wait_gnt(2, 20, "tmo");
      n = 0;
      while (bus.uart_start !== 1'b1 && n < 5) begin step(); n++; end
      saw_done = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (done !== 4'b0) saw_done = 1'b1;
         if (k == 14) begin
            checks++;
            if (err !== 1'b0) begin failures++; $display("FAIL tmo_early: err=%b at 14 cycles want 0", err); end
         end
      end
      checks++;
      if (err !== 1'b1 || fsm_state !== ST_IDLE || saw_done) begin
         failures++;
         $display("FAIL tmo_err: err=%b state=%0d done_seen=%b at 15 cycles, want 1 0 0", err, fsm_state, saw_done);
      end
      expect_txn(2'd1, 8'h99, 1'b0, 1'b0);
      req = 4'b0010;
      wait_gnt(1, 20, "tmo_next");
      repeat (25) step();
      checks++;
      if (err !== 1'b1 || fsm_state !== ST_IDLE) begin
         failures++;
         $display("FAIL tmo_sticky: err=%b state=%0d want 1 0", err, fsm_state);
      end
      stub = 1'b0;
      tx_rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      req_data = 32'h0042_E100;
      expect_txn(2'd1, 8'hE1, 1'b0, 1'b1);
      req = 4'b0010;
      wait_gnt(1, 20, "mid");
      wait_state(ST_WAIT_DONE, 20, "mid");
      repeat (5) step();
      req = 4'b0100;
      expect_txn(2'd2, 8'h42, 1'b1, 1'b1);
      rst_n = 1'b0;
      repeat (2) step();
      check_zero_outputs("mid_reset");
      rst_n = 1'b1;
      n = 0;
      while (bus.uart_busy === 1'b1 && n < 100) begin
         step();
         n++;
         checks++;
         if (bus.uart_start !== 1'b0 || gnt !== 4'b0) begin
            failures++;
            $display("FAIL mid_restart: start=%b gnt=%b while uart busy", bus.uart_start, gnt);
         end
      end
      wait_idle(200, "mid");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_dropout();
      test_timeout();
      test_reset_mid();
      repeat (5) step();
      checks++;
      if (exp_gnt_q.size() != 0 || exp_done_q.size() != 0 || exp_ser_q.size() != 0) begin
         failures++;
         $display("FAIL final_queues: gnt=%0d done=%0d frames=%0d left, want 0",
                  exp_gnt_q.size(), exp_done_q.size(), exp_ser_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one uart_tx.
REQ-002 Parameter START_TIMEOUT, default 15, is the maximum cycles from uart_start to uart_busy high.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  system clock (100 MHz).
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req  in  NUM_REQ  level request per requester.
REQ-007 req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
REQ-008 gnt  out  NUM_REQ  one-cycle pulse: byte of requester i captured.
REQ-009 done  out  NUM_REQ  one-cycle pulse: byte of requester i fully transmitted.
REQ-010 owner  out  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-011 err  out  1  sticky flag: start timeout occurred.
REQ-012 uart_start  out  1  start pulse to uart_tx.
REQ-013 uart_data  out  8  byte to uart_tx data_in.
REQ-014 uart_busy  in  1  uart_tx tx_busy.
REQ-015 uart_done  in  1  uart_tx tx_done.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-017 In IDLE with |req and uart_busy=0, the block SHALL pick the first set req scanning from ptr+1 modulo NUM_REQ.
- It SHALL capture that byte into uart_data and set owner.
- It SHALL pulse gnt[winner] in the next cycle and go to LAUNCH.
REQ-018 In IDLE with uart_busy=1, no grant or start SHALL occur.
REQ-019 LAUNCH SHALL assert uart_start for exactly one cycle (the cycle after gnt), clear the timeout counter and go to WAIT_BUSY.
REQ-020 WAIT_BUSY: uart_busy=1 SHALL go to WAIT_DONE; otherwise the counter increments.
- When the counter reaches START_TIMEOUT, err SHALL set, ptr SHALL become owner, the state SHALL return to IDLE and no done SHALL pulse.
REQ-021 WAIT_DONE: uart_done=1 SHALL pulse done[owner] next cycle, set ptr=owner and return to IDLE.
REQ-022 uart_data SHALL hold stable from capture until the next capture.
REQ-023 uart_done or uart_busy edges outside their waiting states SHALL be ignored.
REQ-024 A req dropped before its gnt SHALL cause no grant; requesters MAY drop req the cycle after gnt.
REQ-025 The next gnt SHALL occur no earlier than the cycle after the previous done or timeout.
REQ-026 Any continuously asserted req SHALL be granted within NUM_REQ transactions.
REQ-027 At most one bit of gnt and at most one bit of done SHALL be high per cycle.
REQ-028 err SHALL clear only on reset.

Reset
REQ-029 With rst_n=0 at a clock edge, the block SHALL enter IDLE and set:
- gnt, done, uart_start, uart_data, owner, err and the counter to 0;
- ptr to NUM_REQ-1, so requester 0 has first priority.
REQ-030 Reset mid-transfer SHALL abandon the transaction without a done pulse; REQ-018 then prevents restart until uart_tx goes idle.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encoding and the default NUM_REQ, START_TIMEOUT and CLKS_PER_BIT constants.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs req and ptr; outputs winner index and a valid flag).

Verification
REQ-033 Bench SHALL instantiate real uart_tx with CLKS_PER_BIT=4 and cover the following scenarios:
REQ-034 req=0100, byte2=A5 -> gnt=0100 for one cycle, uart_start the next cycle, serial frame carries A5, done=0100 once.
REQ-035 After reset, all req high with bytes 11,22,33,44 -> grants in order 0,1,2,3, each done before the next gnt, and uart_start never while uart_busy=1.
REQ-036 req[0] and req[3] held continuously -> grant sequence 0,3,0,3.
REQ-037 Stub with uart_busy stuck 0 -> err=1 START_TIMEOUT cycles after uart_start, no done, and the next req is still granted.
REQ-038 rst_n low during WAIT_DONE with req pending -> outputs 0, no done, and no uart_start until uart_busy falls.
REQ-039 req[1] pulsed for 2 cycles while requester 0 is transmitting -> requester 1 is never granted.
